// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: immediate-size encodings,
// instruction field positions and a field extraction helper.
package decode_pkg;

  // Immediate size selector; both 1x codes pick the 9-bit immediate.
  typedef enum logic [1:0] {
    IMM4  = 2'b00,
    IMM8  = 2'b01,
    IMM9  = 2'b10,
    IMM9X = 2'b11
  } immSize_e;

  localparam int INSTR_W = 16;
  localparam int FIELD_W = 4;
  localparam int RD_HI   = 11;
  localparam int RS_HI   = 7;
  localparam int RT_HI   = 3;
  localparam int IMM9_HI = 8;

  // Pull a 4-bit register field whose top bit sits at position hi.
  function automatic logic [FIELD_W-1:0] getField(input logic [INSTR_W-1:0] instr,
                                                  input int hi);
    return instr[hi -: FIELD_W];
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Two-read / one-write register file with combinational reads.
// Build option: define DECODE_BYPASS_EN to forward same-cycle writeback data
// to a read of the register being written (write-through). Without it a read
// returns the old contents and WB->ID hazards rely on EX forwarding.
module regfile_2r1w #(
  parameter  int DATA_W   = 16,
  parameter  int NREG     = 16,
  parameter  int ZERO_REG = 1,
  localparam int ADDR_W   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd1Addr,
  input  logic [ADDR_W-1:0] rd2Addr,
  output logic [DATA_W-1:0] rd1Data,
  output logic [DATA_W-1:0] rd2Data,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData
);

  logic [DATA_W-1:0] mem_r [NREG];
  logic              wrOk_s;

  // A write to register 0 is dropped when register 0 is hardwired to zero.
  always_comb begin
    wrOk_s = 1'b0;
    if (ZERO_REG != 0 && wrAddr == {ADDR_W{1'b0}}) begin
      wrOk_s = 1'b0;
    end else begin
      wrOk_s = wrEn;
    end
  end

  // Register storage: cleared on reset, one write port on the rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wrOk_s) begin
      mem_r[wrAddr] <= wrData;
    end
  end

  // Read port 1: zero register, optional write-through, else stored value.
  always_comb begin
    rd1Data = {DATA_W{1'b0}};
    if (ZERO_REG != 0 && rd1Addr == {ADDR_W{1'b0}}) begin
      rd1Data = {DATA_W{1'b0}};
    end
`ifdef DECODE_BYPASS_EN
    else if (wrOk_s && wrAddr == rd1Addr) begin
      rd1Data = wrData;
    end
`endif
    else begin
      rd1Data = mem_r[rd1Addr];
    end
  end

  // Read port 2: same selection rules as port 1.
  always_comb begin
    rd2Data = {DATA_W{1'b0}};
    if (ZERO_REG != 0 && rd2Addr == {ADDR_W{1'b0}}) begin
      rd2Data = {DATA_W{1'b0}};
    end
`ifdef DECODE_BYPASS_EN
    else if (wrOk_s && wrAddr == rd2Addr) begin
      rd2Data = wrData;
    end
`endif
    else begin
      rd2Data = mem_r[rd2Addr];
    end
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// Registered instruction-decode stage between IF/ID and ID/EX.
// Extracts register fields, sign-extends the immediate, reads the register
// file, detects load-use hazards and honours branch flush.
// Build option: DECODE_BYPASS_EN enables register-file write-through
// (implemented inside regfile_2r1w).
module decode_stage_pipe
  import decode_pkg::*;
#(
  parameter  int DATA_W   = 16,
  parameter  int NREG     = 16,
  parameter  int ZERO_REG = 1,
  localparam int ADDR_W   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [15:0]       if_instr,
  input  logic [1:0]        imm_size,
  input  logic              reg_src,
  input  logic              ctl_wr,
  input  logic              ctl_ld,
  input  logic              ctl_use2,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_dst,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_rd1,
  output logic [DATA_W-1:0] id_rd2,
  output logic [DATA_W-1:0] id_imm,
  output logic [ADDR_W-1:0] id_dst,
  output logic              id_wr,
  output logic              id_ld
);

  logic [FIELD_W-1:0] rdField_s;
  logic [FIELD_W-1:0] rsField_s;
  logic [FIELD_W-1:0] rtField_s;
  logic [ADDR_W-1:0]  dstAddr_s;
  logic [ADDR_W-1:0]  src1Addr_s;
  logic [ADDR_W-1:0]  src2Addr_s;
  logic [DATA_W-1:0]  rd1Data_s;
  logic [DATA_W-1:0]  rd2Data_s;
  logic [DATA_W-1:0]  imm_s;
  logic               stall_s;
  logic               loadSlot_s;
  logic               unusedBits_s;

  logic               idValid_r;
  logic               idWr_r;
  logic               idLd_r;
  logic [ADDR_W-1:0]  idDst_r;
  logic [DATA_W-1:0]  idRd1_r;
  logic [DATA_W-1:0]  idRd2_r;
  logic [DATA_W-1:0]  idImm_r;

  assign rdField_s  = getField(if_instr, RD_HI);
  assign rsField_s  = getField(if_instr, RS_HI);
  assign rtField_s  = getField(if_instr, RT_HI);
  assign dstAddr_s  = rdField_s[ADDR_W-1:0];
  assign src1Addr_s = rsField_s[ADDR_W-1:0];

  // Opcode bits and any field bits above the register address are not decoded here.
  assign unusedBits_s = ^{if_instr[15:12], rdField_s, rsField_s, rtField_s};

  // Read port 2 address: destination field or rt field.
  always_comb begin
    src2Addr_s = rtField_s[ADDR_W-1:0];
    if (reg_src) begin
      src2Addr_s = rdField_s[ADDR_W-1:0];
    end else begin
      src2Addr_s = rtField_s[ADDR_W-1:0];
    end
  end

  regfile_2r1w #(
    .DATA_W   (DATA_W),
    .NREG     (NREG),
    .ZERO_REG (ZERO_REG)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .rd1Addr (src1Addr_s),
    .rd2Addr (src2Addr_s),
    .rd1Data (rd1Data_s),
    .rd2Data (rd2Data_s),
    .wrEn    (wb_en),
    .wrAddr  (wb_dst),
    .wrData  (wb_data)
  );

  // Sign-extend the immediate selected by imm_size.
  always_comb begin
    imm_s = {DATA_W{1'b0}};
    case (immSize_e'(imm_size))
      IMM4:    imm_s = {{(DATA_W-RT_HI-1){if_instr[RT_HI]}},     if_instr[RT_HI:0]};
      IMM8:    imm_s = {{(DATA_W-RS_HI-1){if_instr[RS_HI]}},     if_instr[RS_HI:0]};
      IMM9:    imm_s = {{(DATA_W-IMM9_HI-1){if_instr[IMM9_HI]}}, if_instr[IMM9_HI:0]};
      IMM9X:   imm_s = {{(DATA_W-IMM9_HI-1){if_instr[IMM9_HI]}}, if_instr[IMM9_HI:0]};
      default: imm_s = {{(DATA_W-IMM9_HI-1){if_instr[IMM9_HI]}}, if_instr[IMM9_HI:0]};
    endcase
  end

  // Load-use hazard: a load in ID/EX whose destination this instruction reads.
  always_comb begin
    stall_s = 1'b0;
    if (!rst) begin
      stall_s = 1'b0;
    end else if (if_valid && idValid_r && idLd_r) begin
      if (ZERO_REG != 0 && idDst_r == {ADDR_W{1'b0}}) begin
        stall_s = 1'b0;
      end else if (idDst_r == src1Addr_s || (ctl_use2 && idDst_r == src2Addr_s)) begin
        stall_s = 1'b1;
      end else begin
        stall_s = 1'b0;
      end
    end else begin
      stall_s = 1'b0;
    end
  end

  assign stall      = stall_s;
  assign loadSlot_s = if_valid & ~flush & ~stall_s;

  // ID/EX register: issue a decoded instruction, or a bubble on stall/flush/empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idValid_r <= 1'b0;
      idWr_r    <= 1'b0;
      idLd_r    <= 1'b0;
      idDst_r   <= {ADDR_W{1'b0}};
      idRd1_r   <= {DATA_W{1'b0}};
      idRd2_r   <= {DATA_W{1'b0}};
      idImm_r   <= {DATA_W{1'b0}};
    end else if (loadSlot_s) begin
      idValid_r <= 1'b1;
      idWr_r    <= ctl_wr;
      idLd_r    <= ctl_ld;
      idDst_r   <= dstAddr_s;
      idRd1_r   <= rd1Data_s;
      idRd2_r   <= rd2Data_s;
      idImm_r   <= imm_s;
    end else begin
      idValid_r <= 1'b0;
      idWr_r    <= 1'b0;
      idLd_r    <= 1'b0;
    end
  end

  assign id_valid = idValid_r;
  assign id_wr    = idWr_r;
  assign id_ld    = idLd_r;
  assign id_dst   = idDst_r;
  assign id_rd1   = idRd1_r;
  assign id_rd2   = idRd2_r;
  assign id_imm   = idImm_r;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Self-checking bench for decode_stage_pipe: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_decode_stage_pipe;

  localparam int DATA_W = 16;
  localparam int NREG   = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_valid;
  logic [15:0]       if_instr;
  logic [1:0]        imm_size;
  logic              reg_src;
  logic              ctl_wr;
  logic              ctl_ld;
  logic              ctl_use2;
  logic              flush;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_dst;
  logic [DATA_W-1:0] wb_data;
  logic              stall;
  logic              id_valid;
  logic [DATA_W-1:0] id_rd1;
  logic [DATA_W-1:0] id_rd2;
  logic [DATA_W-1:0] id_imm;
  logic [ADDR_W-1:0] id_dst;
  logic              id_wr;
  logic              id_ld;

  decode_stage_pipe #(.DATA_W(DATA_W), .NREG(NREG), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr),
    .imm_size(imm_size), .reg_src(reg_src), .ctl_wr(ctl_wr), .ctl_ld(ctl_ld),
    .ctl_use2(ctl_use2), .flush(flush), .wb_en(wb_en), .wb_dst(wb_dst),
    .wb_data(wb_data), .stall(stall), .id_valid(id_valid), .id_rd1(id_rd1),
    .id_rd2(id_rd2), .id_imm(id_imm), .id_dst(id_dst), .id_wr(id_wr), .id_ld(id_ld)
  );

  always #5 clk = ~clk;

  int   vecCount = 0;
  int   errCount = 0;
  logic seenStall = 1'b0;

  // Reference model state: architectural registers and the issued ID/EX slot.
  logic [15:0] mReg [16];
  logic        mValid, mWr, mLd;
  int          mDst;
  logic [15:0] mRd1, mRd2, mImm;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] refImm(input logic [15:0] ins, input logic [1:0] sz);
    int v;
    if (sz == 2'd0) begin
      v = int'(ins) % 16;  if (v >= 8)   v = v - 16;
    end else if (sz == 2'd1) begin
      v = int'(ins) % 256; if (v >= 128) v = v - 256;
    end else begin
      v = int'(ins) % 512; if (v >= 256) v = v - 512;
    end
    return v[15:0];
  endfunction

  function automatic logic [15:0] refRead(input int a);
    if (a == 0) return 16'h0000;
`ifdef DECODE_BYPASS_EN
    if (wb_en && int'(wb_dst) == a) return wb_data;
`endif
    return mReg[a];
  endfunction

  function automatic int srcTwo();
    return reg_src ? (int'(if_instr) / 256) % 16 : int'(if_instr) % 16;
  endfunction

  function automatic logic refStall();
    int rs;
    rs = (int'(if_instr) / 16) % 16;
    return if_valid && mValid && mLd && (mDst != 0) &&
           ((mDst == rs) || (ctl_use2 && mDst == srcTwo()));
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 16; i++) mReg[i] = 16'h0000;
    mValid = 1'b0; mWr = 1'b0; mLd = 1'b0; mDst = 0;
    mRd1 = 16'h0; mRd2 = 16'h0; mImm = 16'h0;
  endtask

  task automatic drive(input logic v, input logic [15:0] ins, input logic [1:0] sz,
                       input logic rsrc, input logic wr, input logic ld, input logic use2,
                       input logic fl, input logic we, input logic [3:0] wd,
                       input logic [15:0] wdat);
    if_valid = v; if_instr = ins; imm_size = sz; reg_src = rsrc; ctl_wr = wr;
    ctl_ld = ld; ctl_use2 = use2; flush = fl; wb_en = we; wb_dst = wd; wb_data = wdat;
  endtask

  // One clock: check stall mid-cycle, advance model at the edge, check ID/EX after.
  task automatic stepCycle();
    logic expStall;
    #1;
    expStall  = refStall();
    seenStall = stall;
    checkEq("stall", {31'd0, stall}, {31'd0, expStall});
    @(posedge clk);
    if (flush || expStall || !if_valid) begin
      mValid = 1'b0; mWr = 1'b0; mLd = 1'b0;
    end else begin
      mValid = 1'b1; mWr = ctl_wr; mLd = ctl_ld;
      mDst   = (int'(if_instr) / 256) % 16;
      mRd1   = refRead((int'(if_instr) / 16) % 16);
      mRd2   = refRead(srcTwo());
      mImm   = refImm(if_instr, imm_size);
    end
    if (wb_en && wb_dst != 4'd0) mReg[wb_dst] = wb_data;
    @(negedge clk);
    checkEq("id_valid", {31'd0, id_valid}, {31'd0, mValid});
    checkEq("id_wr",    {31'd0, id_wr},    {31'd0, mWr});
    checkEq("id_ld",    {31'd0, id_ld},    {31'd0, mLd});
    if (mValid) begin
      checkEq("id_dst", {28'd0, id_dst}, 32'(mDst));
      checkEq("id_rd1", {16'd0, id_rd1}, {16'd0, mRd1});
      checkEq("id_rd2", {16'd0, id_rd2}, {16'd0, mRd2});
      checkEq("id_imm", {16'd0, id_imm}, {16'd0, mImm});
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkEq({tag, "_valid"}, {31'd0, id_valid}, 32'd0);
    checkEq({tag, "_wr"},    {31'd0, id_wr},    32'd0);
    checkEq({tag, "_ld"},    {31'd0, id_ld},    32'd0);
    checkEq({tag, "_dst"},   {28'd0, id_dst},   32'd0);
    checkEq({tag, "_rd1"},   {16'd0, id_rd1},   32'd0);
    checkEq({tag, "_rd2"},   {16'd0, id_rd2},   32'd0);
    checkEq({tag, "_imm"},   {16'd0, id_imm},   32'd0);
    checkEq({tag, "_stall"}, {31'd0, stall},    32'd0);
  endtask

  initial begin
    logic [15:0] expBypass;
    logic [3:0]  fRd, fRs, fRt, fOp;
    rst = 1'b0;
    drive(1'b0, 16'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
    modelReset();
    #12;
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Immediate sign extension and a plain register read.
    drive(1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 16'h1234); stepCycle();
    drive(1'b1, 16'h0330, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0);    stepCycle();
    checkEq("t2_rd1", {16'd0, id_rd1}, 32'h1234);
    checkEq("t2_imm0", {16'd0, id_imm}, 32'h0000);
    drive(1'b1, 16'h0338, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0);    stepCycle();
    checkEq("t2_immneg", {16'd0, id_imm}, 32'hFFF8);

    // Load-use on src1: one stall cycle, then issue.
    drive(1'b1, 16'h0500, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0);    stepCycle();
    drive(1'b1, 16'h0150, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0);    stepCycle();
    checkEq("t3_stall", {31'd0, seenStall}, 32'd1);
    checkEq("t3_bubble", {31'd0, id_valid}, 32'd0);
    stepCycle();
    checkEq("t3_release", {31'd0, seenStall}, 32'd0);
    checkEq("t3_issue", {31'd0, id_valid}, 32'd1);

    // No hazard when only rt matches without use2, or when load targets R0.
    drive(1'b1, 16'h0500, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0);    stepCycle();
    drive(1'b1, 16'h0115, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0);    stepCycle();
    checkEq("t4_rt_nouse2", {31'd0, seenStall}, 32'd0);
    drive(1'b1, 16'h0000, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0);    stepCycle();
    drive(1'b1, 16'h0200, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0);    stepCycle();
    checkEq("t4_r0_load", {31'd0, seenStall}, 32'd0);

    // Flush together with a hazard stall.
    drive(1'b1, 16'h0500, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0);    stepCycle();
    drive(1'b1, 16'h0150, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 16'h0);    stepCycle();
    checkEq("t5_stall", {31'd0, seenStall}, 32'd1);
    checkEq("t5_valid", {31'd0, id_valid}, 32'd0);
    checkEq("t5_wr", {31'd0, id_wr}, 32'd0);
    checkEq("t5_ld", {31'd0, id_ld}, 32'd0);

    // Same-cycle writeback and read of R7; writes to R0 are discarded.
    drive(1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 16'h1111); stepCycle();
    drive(1'b1, 16'h0070, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 16'hBEEF); stepCycle();
`ifdef DECODE_BYPASS_EN
    expBypass = 16'hBEEF;
`else
    expBypass = 16'h1111;
`endif
    checkEq("t6_wb_read", {16'd0, id_rd1}, {16'd0, expBypass});
    drive(1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 16'hFFFF); stepCycle();
    drive(1'b1, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0);    stepCycle();
    checkEq("t6_r0", {16'd0, id_rd1}, 32'h0000);

    // Randomized traffic; fetch holds its instruction while stalled.
    for (int n = 0; n < 400; n++) begin
      if (seenStall && !flush) begin
        flush   = ($urandom_range(0, 9) == 0);
        wb_en   = 1'($urandom_range(0, 1));
        wb_dst  = 4'($urandom_range(0, 7));
        wb_data = 16'($urandom);
      end else begin
        fOp = 4'($urandom); fRd = 4'($urandom_range(0, 7));
        fRs = 4'($urandom_range(0, 7)); fRt = 4'($urandom_range(0, 7));
        drive($urandom_range(0, 4) != 0, {fOp, fRd, fRs, fRt}, 2'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              $urandom_range(0, 9) == 0, 1'($urandom), 4'($urandom_range(0, 7)),
              16'($urandom));
      end
      stepCycle();
    end

    // Asynchronous reset while ID/EX holds a valid instruction.
    drive(1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0); stepCycle();
    drive(1'b1, 16'h0340, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 16'h1234); stepCycle();
    checkEq("pre_rst_valid", {31'd0, id_valid}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    checkAllZero("midrst");
    modelReset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 16'h0330, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0);  stepCycle();
    checkEq("rst_regs", {16'd0, id_rd1}, 32'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
